adc_acq_sequencer: RTL and testbench
====================================

ADC_ACQ_SEQUENCER -- requirements
Module: adc_acq_sequencer

Interface
REQ-001 SHALL have parameter N_CH, default 8, number of ADC channels read per conversion frame (2..16).
REQ-002 SHALL have parameter DATA_W, default 18, ADC sample width in bits.
REQ-003 SHALL have parameter CONV_WAIT, default 24, minimum clock cycles from start pulse to first read (600 ns at 40 MHz).
REQ-004 SHALL have parameter RD_CYCLES, default 2, cycles adc_rd_n is held low per channel read (1..15).
REQ-005 SHALL have the port clock_40MHz, input, 1 bit: the single clock (acquisition clock, 40 MHz); all logic is on its rising edge.
REQ-006 SHALL have the port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have the port ADCs_start_conv, input, 1 bit: one-cycle conversion start pulse, synchronous to clock_40MHz.
REQ-008 SHALL have the port acq_enable, input, 1 bit: acquisition enable, level.
REQ-009 SHALL have the port adc_busy, input, 1 bit: ADC conversion in progress, active-high, asynchronous to clock_40MHz.
REQ-010 SHALL have the port adc_data, input, DATA_W bits: ADC parallel read bus.
REQ-011 SHALL have the port adc_cs_n, output, 1 bit: ADC chip select, active-low.
REQ-012 SHALL have the port adc_rd_n, output, 1 bit: ADC read strobe, active-low.
REQ-013 SHALL have the port sample_data, output, DATA_W bits: captured sample.
REQ-014 SHALL have the port sample_channel, output, 4 bits: channel index of sample_data.
REQ-015 SHALL have the port sample_valid, output, 1 bit: sample available.
REQ-016 SHALL have the port sample_ready, input, 1 bit: consumer accepts sample.
REQ-017 SHALL have the port frame_done, output, 1 bit: one-cycle pulse after the last channel is accepted.
REQ-018 SHALL have the port frame_count, output, 32 bits: completed frames, wraps 0xFFFFFFFF->0.
REQ-019 SHALL have the port overrun, output, 1 bit: sticky flag, start pulse arrived while a frame was in progress.
REQ-020 SHALL have the port overrun_clr, input, 1 bit: clears overrun.

Function
REQ-021 SHALL implement the FSM states IDLE, WAIT_CONV, READ, LATCH, OUTPUT and DONE.
REQ-022 SHALL go IDLE->WAIT_CONV on the cycle after ADCs_start_conv=1 when acq_enable=1; a start pulse arriving while acq_enable=0 is ignored and does not count as overrun.
REQ-023 SHALL pass adc_busy through a 2-flop synchronizer before any use.
REQ-024 SHALL leave WAIT_CONV only when its cycle counter has reached CONV_WAIT and synchronized adc_busy=0; channel index resets to 0 on WAIT_CONV entry.
REQ-025 SHALL, in READ, hold adc_rd_n low for exactly RD_CYCLES cycles and register adc_data on the last one.
REQ-026 SHALL, in LATCH, hold adc_rd_n high for 1 cycle, then enter OUTPUT.
REQ-027 SHALL hold adc_cs_n low from entry to the first READ until DONE; it SHALL be high in all other states.
REQ-028 SHALL, in OUTPUT, assert sample_valid with sample_data and sample_channel stable until the first cycle with sample_ready=1; the transfer occurs on that cycle.
REQ-029 SHALL, after the transfer, go to READ (channel+1) if channel<N_CH-1, otherwise go to DONE.
REQ-030 SHALL, in DONE, pulse frame_done for 1 cycle, increment frame_count, and return to IDLE.
REQ-031 SHALL set overrun when ADCs_start_conv=1 in any state other than IDLE; that pulse is discarded and the current frame continues.
REQ-032 SHALL give set priority over clear when overrun_clr and an overrun event coincide.
REQ-033 SHALL always complete a frame in progress, even if acq_enable falls mid-frame.

Reset
REQ-034 SHALL, on reset_n low, immediately force IDLE, adc_cs_n=1, adc_rd_n=1, sample_valid=0, frame_done=0, sample_data=0, sample_channel=0, frame_count=0 and overrun=0, including mid-frame; release is synchronous to clock_40MHz.

Verification
REQ-035 Nominal case: N_CH=8, start pulse, busy low at cycle 10, ready tied high -> first adc_rd_n fall 25 cycles after pulse; 8 samples with channels 0..7; frame_done 1 pulse; frame_count=1.
REQ-036 Busy stretch case: adc_busy held high for 40 cycles -> no read until 2 cycles after synchronized busy fall.
REQ-037 Backpressure case: sample_ready low for 5 cycles on channel 3 -> sample_valid held, data and channel unchanged, no adc_rd_n activity, no data loss.
REQ-038 Overrun case: second start mid-frame -> overrun=1, frame completes with 8 samples; overrun_clr together with a third mid-frame start -> overrun stays 1.
REQ-039 Reset mid-READ case: reset mid-READ -> adc_cs_n/adc_rd_n high and sample_valid=0 asynchronously; next start pulse gives a clean frame starting at channel 0.
REQ-040 Wrap and enable case: frame_count preset via force to 0xFFFFFFFF, one frame -> 0; acq_enable=0 start pulse -> no activity, overrun stays 0.

Source files
------------

// File: rtl/adc_acq_sequencer.sv
// ADC acquisition sequencer: on a start pulse, waits out the conversion time,
// then reads N_CH channels over the parallel ADC bus. Each sample is handed to
// the consumer with a valid/ready handshake. Frame completion and overruns
// are reported.
module adc_acq_sequencer #(
    parameter int N_CH      = 8,
    parameter int DATA_W    = 18,
    parameter int CONV_WAIT = 24,
    parameter int RD_CYCLES = 2
) (
    input  logic              clock_40MHz,
    input  logic              reset_n,
    input  logic              ADCs_start_conv,
    input  logic              acq_enable,
    input  logic              adc_busy,
    input  logic [DATA_W-1:0] adc_data,
    output logic              adc_cs_n,
    output logic              adc_rd_n,
    output logic [DATA_W-1:0] sample_data,
    output logic [3:0]        sample_channel,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              frame_done,
    output logic [31:0]       frame_count,
    output logic              overrun,
    input  logic              overrun_clr
);

    localparam int WAIT_W = (CONV_WAIT < 2) ? 1 : $clog2(CONV_WAIT + 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_CONV,
        READ,
        LATCH,
        OUTPUT,
        DONE
    } state_t;

    state_t            state;
    logic              busy_meta;
    logic              busy_sync;
    logic [WAIT_W-1:0] wait_cnt;
    logic [3:0]        rd_cnt;
    logic [3:0]        chan;

    // Two-flop synchronizer for the asynchronous ADC busy line
    always_ff @(posedge clock_40MHz or negedge reset_n) begin
        if (!reset_n) begin
            busy_meta <= 1'b0;
            busy_sync <= 1'b0;
        end else begin
            busy_meta <= adc_busy;
            busy_sync <= busy_meta;
        end
    end

    // Sequencer FSM with registered bus strobes, sample handshake and status
    always_ff @(posedge clock_40MHz or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            wait_cnt       <= '0;
            rd_cnt         <= '0;
            chan           <= '0;
            adc_cs_n       <= 1'b1;
            adc_rd_n       <= 1'b1;
            sample_data    <= '0;
            sample_channel <= '0;
            sample_valid   <= 1'b0;
            frame_done     <= 1'b0;
            frame_count    <= '0;
            overrun        <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            // A start pulse outside IDLE is dropped but flagged; set beats clear
            if (ADCs_start_conv && (state != IDLE)) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (ADCs_start_conv && acq_enable) begin
                        // The start cycle itself counts as the first waited cycle
                        wait_cnt <= WAIT_W'(1);
                        chan     <= '0;
                        state    <= WAIT_CONV;
                    end
                end
                WAIT_CONV: begin
                    if ((wait_cnt >= WAIT_W'(CONV_WAIT)) && !busy_sync) begin
                        adc_cs_n <= 1'b0;
                        adc_rd_n <= 1'b0;
                        rd_cnt   <= '0;
                        state    <= READ;
                    end else if (wait_cnt < WAIT_W'(CONV_WAIT)) begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                READ: begin
                    if (rd_cnt == 4'(RD_CYCLES - 1)) begin
                        sample_data    <= adc_data;
                        sample_channel <= chan;
                        adc_rd_n       <= 1'b1;
                        state          <= LATCH;
                    end else begin
                        rd_cnt <= rd_cnt + 4'd1;
                    end
                end
                LATCH: begin
                    sample_valid <= 1'b1;
                    state        <= OUTPUT;
                end
                OUTPUT: begin
                    if (sample_ready) begin
                        sample_valid <= 1'b0;
                        if (chan < 4'(N_CH - 1)) begin
                            chan     <= chan + 4'd1;
                            rd_cnt   <= '0;
                            adc_rd_n <= 1'b0;
                            state    <= READ;
                        end else begin
                            adc_cs_n    <= 1'b1;
                            frame_done  <= 1'b1;
                            frame_count <= frame_count + 32'd1;
                            state       <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_acq_sequencer.sv
// Directed testbench for adc_acq_sequencer: nominal frame, busy stretch,
// backpressure, overrun, asynchronous reset mid-read, frame counter wrap and
// disabled start.
module tb_adc_acq_sequencer;

    localparam int N_CH      = 8;
    localparam int DATA_W    = 18;
    localparam int CONV_WAIT = 24;
    localparam int RD_CYCLES = 2;

    logic              clk;
    logic              reset_n;
    logic              ADCs_start_conv;
    logic              acq_enable;
    logic              adc_busy;
    logic [DATA_W-1:0] adc_data;
    logic              adc_cs_n;
    logic              adc_rd_n;
    logic [DATA_W-1:0] sample_data;
    logic [3:0]        sample_channel;
    logic              sample_valid;
    logic              sample_ready;
    logic              frame_done;
    logic [31:0]       frame_count;
    logic              overrun;
    logic              overrun_clr;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   falls    = 0;
    int   low_cnt  = 0;
    int   low_len  = 0;
    logic prev_rd  = 1'b1;
    logic rd_rose  = 1'b0;

    adc_acq_sequencer #(
        .N_CH     (N_CH),
        .DATA_W   (DATA_W),
        .CONV_WAIT(CONV_WAIT),
        .RD_CYCLES(RD_CYCLES)
    ) dut (
        .clock_40MHz    (clk),
        .reset_n        (reset_n),
        .ADCs_start_conv(ADCs_start_conv),
        .acq_enable     (acq_enable),
        .adc_busy       (adc_busy),
        .adc_data       (adc_data),
        .adc_cs_n       (adc_cs_n),
        .adc_rd_n       (adc_rd_n),
        .sample_data    (sample_data),
        .sample_channel (sample_channel),
        .sample_valid   (sample_valid),
        .sample_ready   (sample_ready),
        .frame_done     (frame_done),
        .frame_count    (frame_count),
        .overrun        (overrun),
        .overrun_clr    (overrun_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ADC bus model value: read number and cycle within the read strobe
    function automatic logic [DATA_W-1:0] mk(input int idx, input int k);
        mk = {6'h15, idx[7:0], k[3:0]};
    endfunction

    // Advance to the next falling edge and update the ADC bus model
    task automatic step();
        @(negedge clk);
        rd_rose = 1'b0;
        if (!adc_rd_n) begin
            if (prev_rd) begin
                falls++;
                low_cnt = 0;
            end
            low_cnt++;
            adc_data = mk(falls, low_cnt);
        end else begin
            if (!prev_rd) begin
                rd_rose = 1'b1;
                low_len = low_cnt;
            end
            adc_data = '1;
        end
        prev_rd = adc_rd_n;
    endtask

    task automatic run_frame(input int busy_low_at, input int stall_ch, input int stall_len,
                             input int extra_at, input logic clr_at_extra, input int en_low_at,
                             output int first_rd, output int nsamp);
        int t, stall_left, exp_ch, base;
        logic done_seen;
        logic [DATA_W-1:0] held_d;
        logic [3:0] held_c;
        base = falls; exp_ch = 0; nsamp = 0; first_rd = -1;
        stall_left = stall_len; done_seen = 1'b0; t = 0;
        held_d = '0; held_c = '0;
        adc_busy = 1'b1; sample_ready = 1'b1; ADCs_start_conv = 1'b1;
        while (!done_seen && t < 600) begin
            step(); t++;
            ADCs_start_conv = 1'b0;
            overrun_clr = 1'b0;
            if (first_rd < 0 && !adc_rd_n) first_rd = t;
            if (rd_rose) check("rd_low_len", low_len, RD_CYCLES);
            if (!adc_rd_n) check("cs_during_rd", 32'(adc_cs_n), 0);
            if (sample_valid) begin
                if (32'(sample_channel) == stall_ch && stall_left > 0) begin
                    if (stall_left == stall_len) begin
                        held_d = sample_data;
                        held_c = sample_channel;
                    end else begin
                        check("bp_data_held", 32'(sample_data), 32'(held_d));
                        check("bp_chan_held", 32'(sample_channel), 32'(held_c));
                    end
                    check("bp_rd_idle", 32'(adc_rd_n), 1);
                    stall_left--;
                    sample_ready = 1'b0;
                end else begin
                    sample_ready = 1'b1;
                    check("sample_chan", 32'(sample_channel), exp_ch);
                    check("sample_data", 32'(sample_data), 32'(mk(base + exp_ch + 1, RD_CYCLES)));
                    exp_ch++;
                    nsamp++;
                end
            end else begin
                sample_ready = 1'b1;
            end
            if (frame_done) begin
                done_seen = 1'b1;
                check("cs_at_done", 32'(adc_cs_n), 1);
            end
            if (t == busy_low_at) adc_busy = 1'b0;
            if (t == extra_at) begin
                ADCs_start_conv = 1'b1;
                overrun_clr = clr_at_extra;
            end
            if (t == en_low_at) acq_enable = 1'b0;
        end
        check("frame_finished", 32'(done_seen), 1);
        step();
        check("frame_done_pulse", 32'(frame_done), 0);
        acq_enable = 1'b1;
        ADCs_start_conv = 1'b0;
        overrun_clr = 1'b0;
    endtask

    initial begin
        int first_rd, nsamp, base, k, act;
        reset_n = 1'b0; ADCs_start_conv = 1'b0; acq_enable = 1'b1; adc_busy = 1'b0;
        adc_data = '1; sample_ready = 1'b1; overrun_clr = 1'b0;
        repeat (3) step();
        check("rst_cs_n", 32'(adc_cs_n), 1);
        check("rst_rd_n", 32'(adc_rd_n), 1);
        check("rst_valid", 32'(sample_valid), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_data", 32'(sample_data), 0);
        check("rst_chan", 32'(sample_channel), 0);
        check("rst_frame_count", frame_count, 0);
        check("rst_overrun", 32'(overrun), 0);
        reset_n = 1'b1;
        repeat (2) step();

        // Nominal frame: busy drops at cycle 10, first read 25 cycles after the pulse
        run_frame(10, -1, 0, -1, 1'b0, -1, first_rd, nsamp);
        check("nom_first_rd", first_rd, 25);
        check("nom_samples", nsamp, N_CH);
        check("nom_frame_count", frame_count, 1);

        // Busy held 40 cycles: two synchronizer flops plus the registered transition
        run_frame(40, -1, 0, -1, 1'b0, -1, first_rd, nsamp);
        check("busy_first_rd", first_rd, 43);
        check("busy_samples", nsamp, N_CH);

        // Backpressure on channel 3 for 5 cycles
        run_frame(5, 3, 5, -1, 1'b0, -1, first_rd, nsamp);
        check("bp_samples", nsamp, N_CH);
        check("bp_frame_count", frame_count, 3);
        check("bp_overrun", 32'(overrun), 0);

        // Second start mid-frame sets overrun; frame still completes
        run_frame(5, -1, 0, 40, 1'b0, -1, first_rd, nsamp);
        check("ovr_set", 32'(overrun), 1);
        check("ovr_samples", nsamp, N_CH);
        check("ovr_frame_count", frame_count, 4);

        // Clear coinciding with another overrun event: set wins
        run_frame(5, -1, 0, 40, 1'b1, -1, first_rd, nsamp);
        check("ovr_set_priority", 32'(overrun), 1);
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        step();
        check("ovr_cleared", 32'(overrun), 0);

        // Asynchronous reset during the third channel read
        base = falls; adc_busy = 1'b0; ADCs_start_conv = 1'b1;
        step();
        ADCs_start_conv = 1'b0;
        k = 0;
        while ((falls - base) < 3 && k < 200) begin
            step();
            k++;
        end
        check("rst_mid_reached", 32'(falls - base), 3);
        check("rst_mid_in_read", 32'(adc_rd_n), 0);
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_cs_n", 32'(adc_cs_n), 1);
        check("rst_mid_rd_n", 32'(adc_rd_n), 1);
        check("rst_mid_valid", 32'(sample_valid), 0);
        check("rst_mid_data", 32'(sample_data), 0);
        check("rst_mid_chan", 32'(sample_channel), 0);
        check("rst_mid_frame_count", frame_count, 0);
        repeat (2) step();
        reset_n = 1'b1;
        repeat (2) step();
        run_frame(10, -1, 0, -1, 1'b0, -1, first_rd, nsamp);
        check("post_rst_first_rd", first_rd, 25);
        check("post_rst_samples", nsamp, N_CH);
        check("post_rst_frame_count", frame_count, 1);

        // Frame counter wrap, with acq_enable dropped mid-frame
        force dut.frame_count = 32'hFFFF_FFFF;
        step();
        release dut.frame_count;
        step();
        check("wrap_preset", frame_count, 32'hFFFF_FFFF);
        run_frame(5, -1, 0, -1, 1'b0, 30, first_rd, nsamp);
        check("en_drop_samples", nsamp, N_CH);
        check("wrap_frame_count", frame_count, 0);

        // Start pulse with acquisition disabled is ignored
        acq_enable = 1'b0;
        ADCs_start_conv = 1'b1;
        act = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            ADCs_start_conv = 1'b0;
            if (!adc_cs_n || !adc_rd_n || sample_valid) act++;
        end
        check("dis_activity", act, 0);
        check("dis_overrun", 32'(overrun), 0);
        check("dis_frame_count", frame_count, 0);
        acq_enable = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
